// File: rtl/csi2rx_raw7_b2p.sv
// CSI-2 RAW7 unpacker: 32-bit LSB-first payload words in, one 7-bit pixel per fire out (macro CSI2RX_RAW7_LEN_CHK_EN enables len_err).
// Latency: first pixel is valid the cycle after the word holding its last bit is accepted.
// Backpressure: dw_rdy drops while >= 7 bits are buffered; pixel_data/pixel_last hold while pixel_rdy is low.
module csi2rx_raw7_b2p #(
    parameter int DW_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            raw7_convrn_enable,
    input  logic            line_start,
    input  logic [15:0]     line_pixels,
    input  logic [DW_W-1:0] dw,
    input  logic            dw_vld,
    input  logic            dw_last,
    output logic            dw_rdy,
    output logic [6:0]      pixel_data,
    output logic            pixel_vld,
    output logic            pixel_last,
    input  logic            pixel_rdy,
    output logic            len_err
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [37:0] buf_q, buf_d;
    logic [5:0]  fill_q, fill_d;
    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic [15:0] lp_q, lp_d;
    logic        last_seen_q, last_seen_d;
`ifdef CSI2RX_RAW7_LEN_CHK_EN
    logic        len_err_q, len_err_d;
`endif

    logic        has_pix, dw_rdy_int, pix_vld_int, pix_last_int, dw_acc, pix_fire, gate;
    logic [37:0] dw_ext;

    assign dw_ext       = {{(38-DW_W){1'b0}}, dw};
    assign has_pix      = (fill_q >= 6'd7);
    assign dw_rdy_int   = ((state_q == ACTIVE) && !has_pix && !last_seen_q) || (state_q == DRAIN);
    assign pix_vld_int  = (state_q == ACTIVE) && has_pix;
    assign pix_last_int = pix_vld_int && (pix_cnt_q == lp_q - 16'd1);
    assign dw_acc       = dw_vld && dw_rdy_int;
    assign pix_fire     = pix_vld_int && pixel_rdy;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        fill_d      = fill_q;
        pix_cnt_d   = pix_cnt_q;
        lp_d        = lp_q;
        last_seen_d = last_seen_q;
`ifdef CSI2RX_RAW7_LEN_CHK_EN
        len_err_d   = 1'b0;
`endif
        if (!raw7_convrn_enable) begin
            state_d     = IDLE;
            buf_d       = '0;
            fill_d      = '0;
            pix_cnt_d   = '0;
            lp_d        = '0;
            last_seen_d = 1'b0;
        end else if (line_start) begin
            // A line_start mid-line is an abort; only an abort from ACTIVE is an error.
            buf_d       = '0;
            fill_d      = '0;
            pix_cnt_d   = '0;
            last_seen_d = 1'b0;
            lp_d        = line_pixels;
            state_d     = (line_pixels == 16'd0) ? DRAIN : ACTIVE;
`ifdef CSI2RX_RAW7_LEN_CHK_EN
            len_err_d   = (state_q == ACTIVE);
`endif
        end else begin
            case (state_q)
                ACTIVE: begin
                    if (dw_acc) begin
                        buf_d  = buf_q | (dw_ext << fill_q);
                        fill_d = fill_q + 6'd32;
                        if (dw_last) last_seen_d = 1'b1;
                    end else if (pix_fire) begin
                        pix_cnt_d = pix_cnt_q + 16'd1;
                        if (pix_last_int) begin
                            buf_d   = '0;
                            fill_d  = '0;
                            state_d = last_seen_q ? IDLE : DRAIN;
                        end else begin
                            buf_d  = buf_q >> 7;
                            fill_d = fill_q - 6'd7;
                        end
                    end else if (!has_pix && last_seen_q) begin
                        // Payload ended before the line's pixel count was reached.
                        state_d = IDLE;
                        buf_d   = '0;
                        fill_d  = '0;
`ifdef CSI2RX_RAW7_LEN_CHK_EN
                        len_err_d = 1'b1;
`endif
                    end
                end
                DRAIN: begin
                    if (dw_acc && dw_last) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            fill_q      <= '0;
            pix_cnt_q   <= '0;
            lp_q        <= '0;
            last_seen_q <= 1'b0;
`ifdef CSI2RX_RAW7_LEN_CHK_EN
            len_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            pix_cnt_q   <= pix_cnt_d;
            lp_q        <= lp_d;
            last_seen_q <= last_seen_d;
`ifdef CSI2RX_RAW7_LEN_CHK_EN
            len_err_q   <= len_err_d;
`endif
        end
    end

    assign gate       = raw7_convrn_enable && !rst;
    assign dw_rdy     = gate && dw_rdy_int;
    assign pixel_vld  = gate && pix_vld_int;
    assign pixel_last = gate && pix_last_int;
    assign pixel_data = gate ? buf_q[6:0] : 7'd0;
`ifdef CSI2RX_RAW7_LEN_CHK_EN
    assign len_err    = gate && len_err_q;
`else
    assign len_err    = 1'b0;
`endif

endmodule

// File: tb/tb_csi2rx_raw7_b2p.sv
// Directed bench for csi2rx_raw7_b2p: hand-computed pixel streams, stalls, drain, short payload, reset/enable aborts.
module tb_csi2rx_raw7_b2p;

`ifdef CSI2RX_RAW7_LEN_CHK_EN
    localparam int LCHK = 1;
`else
    localparam int LCHK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, raw7_convrn_enable, line_start, dw_vld, dw_last, pixel_rdy;
    logic [15:0] line_pixels;
    logic [31:0] dw;
    logic        dw_rdy, pixel_vld, pixel_last, len_err;
    logic [6:0]  pixel_data;

    logic [31:0] words [0:7];
    logic [6:0]  expv  [0:31];
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    csi2rx_raw7_b2p #(.DW_W(32)) dut (
        .clk(clk), .rst(rst), .raw7_convrn_enable(raw7_convrn_enable),
        .line_start(line_start), .line_pixels(line_pixels),
        .dw(dw), .dw_vld(dw_vld), .dw_last(dw_last), .dw_rdy(dw_rdy),
        .pixel_data(pixel_data), .pixel_vld(pixel_vld), .pixel_last(pixel_last),
        .pixel_rdy(pixel_rdy), .len_err(len_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_dw_rdy"}, dw_rdy, 0);
        chk({tag, "_pix_vld"}, pixel_vld, 0);
        chk({tag, "_pix_last"}, pixel_last, 0);
        chk({tag, "_pix_data"}, pixel_data, 0);
        chk({tag, "_len_err"}, len_err, 0);
    endtask

    task automatic run_line(input int lp, input int nw, input int exp_n, input int exp_lerr,
                            input int stall_at, input bit chk_lat);
        int  wi = 0, k = 0, stall = 0, lerr = 0, cyc = 0, tail = 0;
        int  acc_cyc = -1, pix_cyc = -1;
        bit  acc, fire;
        line_start  = 1'b1;
        line_pixels = 16'(lp);
        tick();
        line_start = 1'b0;
        while (tail < 4 && cyc < 400) begin
            if (len_err) lerr++;
            pixel_rdy = !(pixel_vld && k == stall_at && stall < 3);
            if (pixel_vld && !pixel_rdy) begin
                stall++;
                chk("stall_data", pixel_data, expv[k]);
            end
            fire = pixel_vld && pixel_rdy;
            if (fire) begin
                if (pix_cyc < 0) pix_cyc = cyc;
                if (k < exp_n) begin
                    chk("pix_data", pixel_data, expv[k]);
                    chk("pix_last", pixel_last, (k == lp - 1) ? 1 : 0);
                end else begin
                    chk("extra_pixel", k, exp_n);
                end
                k++;
            end
            dw_vld  = (wi < nw);
            dw      = dw_vld ? words[wi] : 32'd0;
            dw_last = dw_vld && (wi == nw - 1);
            acc     = dw_vld && dw_rdy;
            if (acc && acc_cyc < 0) acc_cyc = cyc;
            if (k >= exp_n && wi >= nw) tail++;
            tick();
            cyc++;
            if (acc) wi++;
        end
        dw_vld    = 1'b0;
        dw_last   = 1'b0;
        pixel_rdy = 1'b1;
        chk("timeout", (cyc < 400) ? 1 : 0, 1);
        chk("pix_count", k, exp_n);
        chk("len_err_pulses", lerr, exp_lerr);
        chk("idle_dw_rdy", dw_rdy, 0);
        chk("idle_pix_vld", pixel_vld, 0);
        if (chk_lat) chk("first_pix_latency", pix_cyc - acc_cyc, 1);
    endtask

    task automatic setup_basic();
        words[0] = 32'h5080C101;
        words[1] = 32'h00000000;
        for (int i = 0; i < 5; i++) expv[i] = 7'(i + 1);
    endtask

    task automatic partial_line();
        line_start  = 1'b1;
        line_pixels = 16'd5;
        tick();
        line_start = 1'b0;
        dw_vld = 1'b1;
        dw     = 32'h5080C101;
        tick();
        dw_vld = 1'b0;
        chk("partial_pix_vld", pixel_vld, 1);
        chk("partial_pix_data", pixel_data, 7'h01);
    endtask

    initial begin
        rst = 1'b1; raw7_convrn_enable = 1'b1; line_start = 1'b0; line_pixels = '0;
        dw = '0; dw_vld = 1'b0; dw_last = 1'b0; pixel_rdy = 1'b1;
        tick(); tick();
        chk_outs_zero("reset");
        rst = 1'b0;
        tick();
        chk_outs_zero("idle");

        setup_basic();
        run_line(5, 2, 5, 0, -1, 1'b1);

        for (int i = 0; i < 7; i++) words[i] = 32'hFFFFFFFF;
        for (int i = 0; i < 32; i++) expv[i] = 7'h7F;
        run_line(32, 7, 32, 0, -1, 1'b0);

        setup_basic();
        run_line(10, 1, 4, LCHK, -1, 1'b0);

        setup_basic();
        run_line(5, 2, 5, 0, 2, 1'b0);

        setup_basic();
        run_line(3, 2, 3, 0, -1, 1'b0);

        partial_line();
        rst = 1'b1;
        tick();
        chk_outs_zero("mid_rst");
        rst = 1'b0;
        tick();
        chk_outs_zero("post_rst");
        run_line(5, 2, 5, 0, -1, 1'b0);

        partial_line();
        raw7_convrn_enable = 1'b0;
        tick();
        chk_outs_zero("en_low");
        raw7_convrn_enable = 1'b1;
        tick();
        chk_outs_zero("en_back");
        run_line(5, 2, 5, 0, -1, 1'b0);

        partial_line();
        run_line(5, 2, 5, LCHK, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
